ct_ifu_bht_gen2: RTL and testbench
==================================

# ct_ifu_bht_gen2

Parametrised second-generation branch history table for the IFU: a gshare-indexed array of saturating counters with a speculative global history (VGHR) and a retire-side global history (RTU GHR). Widths, depth and retire-port count are all parameters. Includes a hardware sweep-invalidate state machine and flush-time VGHR recovery. It sits between pcgen/ipctrl (prediction), the IU (training) and the RTU (retire history).

## Interface
- IDX_W, 10, index width; table depth = 2^IDX_W entries.
- GHR_W, 22, history width; must be >= IDX_W.
- CNT_W, 2, counter width.
- RET_PORTS, 3, retire ports per cycle (1..4).
- forever_cpuclk in 1: sole clock.
- cpurst in 1: reset, synchronous, active-high.
- bht_en in 1: enables prediction and training.
- inv_req in 1: start a sweep invalidate.
- inv_on out 1: sweep in progress.
- inv_done out 1: one-cycle pulse when the sweep completes.
- pred_vld in 1: prediction lookup request.
- pred_pc_idx in IDX_W: PC index bits.
- pred_out_vld out 1: prediction result valid.
- pred_cnt out CNT_W: counter read.
- pred_taken out 1: MSB of pred_cnt.
- spec_upd_vld in 1: speculative conditional branch.
- spec_taken in 1: its predicted direction.
- upd_vld in 1: train request.
- upd_idx in IDX_W: hashed index captured at lookup.
- upd_taken in 1: resolved direction.
- ret_condbr in RET_PORTS: retiring conditional branch; bit 0 is the oldest.
- ret_taken in RET_PORTS: retire direction.
- flush in 1: restore VGHR.
- vghr out GHR_W: speculative history.
- rtu_ghr out GHR_W: retired history.

## Operation
- Lookup index = pred_pc_idx XOR vghr[IDX_W-1:0], using vghr as it stands in the request cycle.
- Counters saturate: +1 on taken up to 2^CNT_W-1, -1 on not-taken down to 0. Training is a read-modify-write of the entry at upd_idx in a single cycle.
- FSM states:
  - INV: pointer p writes entry p to weakly-not-taken (MSB=0, other bits 1; 01 for CNT_W=2). p increments each cycle. After writing entry 2^IDX_W-1, move to IDLE.
  - IDLE: normal operation. inv_req moves to INV with p=0.
- Reset forces INV with p=0. The table is never exposed uninitialised.
- While in INV:
  - inv_on=1.
  - pred_out_vld=0.
  - upd_vld is dropped.
  - inv_req is ignored.
  - GHR logic keeps running.
- bht_en=0:
  - pred_out_vld=0.
  - Training is dropped.
  - GHRs still update.
  - An inv_req is still honoured.
- VGHR: spec_upd_vld shifts it left by one, inserting spec_taken at bit 0.
- RTU GHR: the k valid retire ports shift it left by k. Directions are inserted in port order, oldest first, so the youngest lands in bit 0. Invalid ports are compacted out.
- flush: vghr <= the rtu_ghr next-state value, which includes retires in the same cycle. Flush has priority over spec_upd_vld in the same cycle.
- Read/write collision (same cycle, same index, IDLE): pred_cnt returns the pre-update value unless the bypass configuration below is enabled.
- Reset values:
  - inv_on=1, inv_done=0.
  - pred_out_vld=0, pred_cnt=0, pred_taken=0.
  - vghr=0, rtu_ghr=0.

## Timing
- Lookup: pred_vld in cycle N gives pred_out_vld/pred_cnt registered in cycle N+1. There is no back-pressure. pred_out_vld is the registered value of pred_vld && IDLE && bht_en.
- Training: write visible to a lookup issued in cycle N+1 or later.
- After reset release, inv_on stays high for exactly 2^IDX_W cycles. inv_done is high for one cycle, the first cycle inv_on is low.
- After inv_req in IDLE cycle N: inv_on rises in N+1 and the same sweep length applies.
- GHR updates and flush take effect on the next edge; the outputs are registers.
- cpurst asserted mid-sweep or mid-operation restarts INV at p=0. Any pending pred_out_vld is cleared.

## Configuration
- CT_IFU_BHT_BYPASS_EN defined: a same-cycle train to the lookup index forwards the post-update counter to pred_cnt/pred_taken in N+1.
- Undefined: no forwarding, and pred_cnt returns the pre-update value.
- The macro affects only this collision path.

## Test plan
- Reset with defaults:
  - inv_on=1 for 1024 cycles, then inv_done for 1 cycle.
  - A lookup at pc_idx 0x252 with vghr=0 returns pred_cnt=01, pred_taken=0.
- Training and saturation:
  - Train idx 0x252 taken three times: a lookup returns 11, pred_taken=1.
  - A fourth taken keeps 11.
  - Four not-taken give 00 and stay there.
- Hash:
  - spec_upd_vld with taken, twice: vghr=0x3.
  - A lookup at pc_idx 0x252 reads entry 0x251.
- Retire compaction:
  - ret_condbr=101, ret_taken=001 from rtu_ghr=0: rtu_ghr=0x2.
  - Same cycle with flush=1 and spec_upd_vld=1: vghr=0x2.
- Collision:
  - Entry 0x010=01; train taken and look up 0x010 in the same cycle.
  - Returns 01 without CT_IFU_BHT_BYPASS_EN, 10 with it.
- Invalidate mid-operation:
  - inv_req during a lookup: pred_out_vld=0 through the sweep, training is dropped, and every entry reads 01 after inv_done.
  - cpurst at p=500: inv_on stays high for a further 1024 cycles.

Source files
------------

// File: rtl/ct_ifu_bht_gen2.sv
// ct_ifu_bht_gen2: second-generation IFU branch history table.
//
// The table is an array of 2^IDX_W saturating counters. Lookups use a gshare index, the PC index
// XOR the low history bits. Speculative history (vghr) is updated from predicted conditional
// branches. Retire history (rtu_ghr) is updated from the retire ports. A flush restores vghr from
// the retire history.
//
// A sweep state machine sets every entry to weakly-not-taken. The sweep runs after reset and
// after inv_req. While it runs, prediction and training are suppressed and the history logic keeps
// running.
//
// Build option: define CT_IFU_BHT_BYPASS_EN to forward a same-cycle training result to a lookup
// of the same index. When it is undefined, that lookup returns the pre-update counter.
//
// Ports:
//   forever_cpuclk, cpurst      clock; synchronous active-high reset
//   bht_en                      enables prediction and training
//   inv_req / inv_on / inv_done sweep request, sweep busy, one-cycle completion pulse
//   pred_vld, pred_pc_idx       lookup request
//   pred_out_vld, pred_cnt,     registered lookup result; pred_taken is the counter MSB
//   pred_taken
//   spec_upd_vld, spec_taken    speculative history shift
//   upd_vld, upd_idx, upd_taken training request at a pre-hashed index
//   ret_condbr, ret_taken       retire ports, bit 0 is the oldest
//   flush                       restore vghr from the retire history
//   vghr, rtu_ghr               speculative and retired global histories
module ct_ifu_bht_gen2 #(
  parameter int unsigned IDX_W     = 10,
  parameter int unsigned GHR_W     = 22,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned RET_PORTS = 3
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 bht_en,
  input  logic                 inv_req,
  output logic                 inv_on,
  output logic                 inv_done,
  input  logic                 pred_vld,
  input  logic [IDX_W-1:0]     pred_pc_idx,
  output logic                 pred_out_vld,
  output logic [CNT_W-1:0]     pred_cnt,
  output logic                 pred_taken,
  input  logic                 spec_upd_vld,
  input  logic                 spec_taken,
  input  logic                 upd_vld,
  input  logic [IDX_W-1:0]     upd_idx,
  input  logic                 upd_taken,
  input  logic [RET_PORTS-1:0] ret_condbr,
  input  logic [RET_PORTS-1:0] ret_taken,
  input  logic                 flush,
  output logic [GHR_W-1:0]     vghr,
  output logic [GHR_W-1:0]     rtu_ghr
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LastIdx = {IDX_W{1'b1}};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  // MSB clear, all lower bits set: weakly not-taken.
  localparam logic [CNT_W-1:0] CntWeakNt = CntMax >> 1;

  if (GHR_W < IDX_W) begin : g_bad_ghr_w
    $error("GHR_W must be >= IDX_W");
  end
  if (RET_PORTS < 1 || RET_PORTS > 4) begin : g_bad_ret_ports
    $error("RET_PORTS must be in 1..4");
  end

  typedef enum logic [0:0] {StInv, StIdle} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             inv_done_q, inv_done_d;
  logic             pred_out_vld_q, pred_out_vld_d;
  logic [CNT_W-1:0] pred_cnt_q, pred_cnt_d;
  logic [GHR_W-1:0] vghr_q, vghr_d;
  logic [GHR_W-1:0] rtu_ghr_q, rtu_ghr_d;

  // Counter array. It has no reset because the sweep writes every entry before it is read.
  logic [CNT_W-1:0] mem_q [Depth];

  logic             is_idle;
  logic             train_en;
  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_new;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CNT_W-1:0] wr_data;
  logic [IDX_W-1:0] lkp_idx;
  logic             lkp_vld;
  logic [CNT_W-1:0] lkp_raw;
  logic [CNT_W-1:0] lkp_cnt;

  // Sweep FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    inv_done_d = 1'b0;
    unique case (state_q)
      StInv: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LastIdx) begin
          state_d    = StIdle;
          inv_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (inv_req) begin
          state_d = StInv;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = StInv;
        ptr_d   = '0;
      end
    endcase
  end

  // Table write port. The sweep owns the port while it runs, and training is dropped then.
  always_comb begin
    is_idle  = (state_q == StIdle);
    train_en = is_idle && bht_en && upd_vld;
    upd_cur  = mem_q[upd_idx];
    upd_new  = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CntMax) upd_new = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_new = upd_cur - 1'b1;
    end
    wr_en   = !is_idle || train_en;
    wr_idx  = is_idle ? upd_idx : ptr_q;
    wr_data = is_idle ? upd_new : CntWeakNt;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Lookup. The index hashes with vghr as it stands in the request cycle.
  always_comb begin
    lkp_idx = pred_pc_idx ^ vghr_q[IDX_W-1:0];
    lkp_vld = pred_vld && is_idle && bht_en;
    lkp_raw = mem_q[lkp_idx];
`ifdef CT_IFU_BHT_BYPASS_EN
    lkp_cnt = (train_en && (upd_idx == lkp_idx)) ? upd_new : lkp_raw;
`else
    lkp_cnt = lkp_raw;
`endif
    pred_out_vld_d = lkp_vld;
    // Hold the last result when no lookup completes.
    pred_cnt_d     = lkp_vld ? lkp_cnt : pred_cnt_q;
  end

  // Histories. Valid retire ports shift in oldest first, so invalid ports are compacted out.
  // The youngest retire ends up in bit 0.
  always_comb begin
    rtu_ghr_d = rtu_ghr_q;
    for (int i = 0; i < int'(RET_PORTS); i++) begin
      if (ret_condbr[i]) begin
        rtu_ghr_d = {rtu_ghr_d[GHR_W-2:0], ret_taken[i]};
      end
    end
    if (flush) begin
      vghr_d = rtu_ghr_d;
    end else if (spec_upd_vld) begin
      vghr_d = {vghr_q[GHR_W-2:0], spec_taken};
    end else begin
      vghr_d = vghr_q;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q        <= StInv;
      ptr_q          <= '0;
      inv_done_q     <= 1'b0;
      pred_out_vld_q <= 1'b0;
      pred_cnt_q     <= '0;
      vghr_q         <= '0;
      rtu_ghr_q      <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      inv_done_q     <= inv_done_d;
      pred_out_vld_q <= pred_out_vld_d;
      pred_cnt_q     <= pred_cnt_d;
      vghr_q         <= vghr_d;
      rtu_ghr_q      <= rtu_ghr_d;
    end
  end

  assign inv_on       = (state_q == StInv);
  assign inv_done     = inv_done_q;
  assign pred_out_vld = pred_out_vld_q;
  assign pred_cnt     = pred_cnt_q;
  assign pred_taken   = pred_cnt_q[CNT_W-1];
  assign vghr         = vghr_q;
  assign rtu_ghr      = rtu_ghr_q;

endmodule

// File: tb/tb_ct_ifu_bht_gen2.sv
module tb_ct_ifu_bht_gen2;

  localparam int IDX_W     = 10;
  localparam int GHR_W     = 22;
  localparam int CNT_W     = 2;
  localparam int RET_PORTS = 3;
  localparam int DEPTH     = 1 << IDX_W;
  localparam int unsigned GMOD = 1 << GHR_W;
`ifdef CT_IFU_BHT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 cpurst, bht_en, inv_req, pred_vld, spec_upd_vld, spec_taken;
  logic                 upd_vld, upd_taken, flush;
  logic [IDX_W-1:0]     pred_pc_idx, upd_idx;
  logic [RET_PORTS-1:0] ret_condbr, ret_taken;
  logic                 inv_on, inv_done, pred_out_vld, pred_taken;
  logic [CNT_W-1:0]     pred_cnt;
  logic [GHR_W-1:0]     vghr, rtu_ghr;

  ct_ifu_bht_gen2 #(
    .IDX_W(IDX_W), .GHR_W(GHR_W), .CNT_W(CNT_W), .RET_PORTS(RET_PORTS)
  ) dut (
    .forever_cpuclk(clk), .cpurst(cpurst), .bht_en(bht_en), .inv_req(inv_req),
    .inv_on(inv_on), .inv_done(inv_done), .pred_vld(pred_vld), .pred_pc_idx(pred_pc_idx),
    .pred_out_vld(pred_out_vld), .pred_cnt(pred_cnt), .pred_taken(pred_taken),
    .spec_upd_vld(spec_upd_vld), .spec_taken(spec_taken), .upd_vld(upd_vld),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .ret_condbr(ret_condbr),
    .ret_taken(ret_taken), .flush(flush), .vghr(vghr), .rtu_ghr(rtu_ghr)
  );

  // Reference model: counter values as plain integers, sweep as a count of cycles remaining.
  int          m_mem [DEPTH];
  int          m_sweep;
  int unsigned m_vghr, m_rtu;
  int          m_cnt;

  typedef struct {
    bit vld;
    int cnt;
    int unsigned vghr;
    int unsigned rtu;
    bit inv_on;
    bit inv_done;
  } exp_t;
  exp_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int sat(int c, bit t);
    if (t) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic defaults();
    cpurst = 1'b0; bht_en = 1'b1; inv_req = 1'b0; pred_vld = 1'b0; pred_pc_idx = '0;
    spec_upd_vld = 1'b0; spec_taken = 1'b0; upd_vld = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    ret_condbr = '0; ret_taken = '0; flush = 1'b0;
  endtask

  // Apply the current inputs for one clock: advance the model, queue the expected
  // post-edge outputs, and move to the next falling edge.
  task automatic step();
    exp_t e;
    bit   idle, tr;
    int   idx, nc;
    e.vld = 1'b0;
    e.inv_done = 1'b0;
    if (cpurst) begin
      m_sweep = DEPTH; m_vghr = 0; m_rtu = 0; m_cnt = 0;
    end else begin
      idle = (m_sweep == 0);
      idx  = int'(pred_pc_idx) ^ int'(m_vghr % DEPTH);
      tr   = upd_vld && idle && bht_en;
      nc   = sat(m_mem[upd_idx], upd_taken);
      e.vld = pred_vld && idle && bht_en;
      if (e.vld) m_cnt = (BYPASS && tr && int'(upd_idx) == idx) ? nc : m_mem[idx];
      if (tr) m_mem[upd_idx] = nc;
      if (!idle) begin
        m_mem[DEPTH - m_sweep] = 1;
        m_sweep--;
        e.inv_done = (m_sweep == 0);
      end else if (inv_req) begin
        m_sweep = DEPTH;
      end
      for (int p = 0; p < RET_PORTS; p++)
        if (ret_condbr[p]) m_rtu = (m_rtu * 2 + ret_taken[p]) % GMOD;
      if (flush) m_vghr = m_rtu;
      else if (spec_upd_vld) m_vghr = (m_vghr * 2 + spec_taken) % GMOD;
    end
    e.cnt = m_cnt; e.vghr = m_vghr; e.rtu = m_rtu; e.inv_on = (m_sweep != 0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic lookup(int entry);
    pred_vld = 1'b1;
    pred_pc_idx = IDX_W'(entry ^ int'(m_vghr % DEPTH));
  endtask

  task automatic train(int entry, bit t);
    upd_vld = 1'b1; upd_idx = IDX_W'(entry); upd_taken = t;
  endtask

  // Monitor: one expectation per clock, compared shortly after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pred_out_vld", 32'(pred_out_vld), 32'(e.vld));
      if (e.vld) begin
        chk("pred_cnt", 32'(pred_cnt), 32'(e.cnt));
        chk("pred_taken", 32'(pred_taken), 32'(e.cnt >> 1));
      end
      chk("vghr", 32'(vghr), e.vghr);
      chk("rtu_ghr", 32'(rtu_ghr), e.rtu);
      chk("inv_on", 32'(inv_on), 32'(e.inv_on));
      chk("inv_done", 32'(inv_done), 32'(e.inv_done));
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = -1;
    m_sweep = DEPTH; m_vghr = 0; m_rtu = 0; m_cnt = 0;
    defaults();
    cpurst = 1'b1;
    repeat (3) step();
    cpurst = 1'b0;
    repeat (DEPTH + 4) step();

    // Post-sweep lookup, then training and saturation at 0x252.
    lookup('h252); step(); defaults();
    for (int i = 0; i < 3; i++) begin train('h252, 1'b1); step(); defaults(); end
    lookup('h252); step(); defaults();
    train('h252, 1'b1); step(); defaults();
    lookup('h252); step(); defaults();
    for (int i = 0; i < 5; i++) begin train('h252, 1'b0); step(); defaults(); end
    lookup('h252); step(); defaults();

    // Hash: make 0x251 strongly taken, shift two taken bits in, then look up pc 0x252.
    for (int i = 0; i < 2; i++) begin train('h251, 1'b1); step(); defaults(); end
    for (int i = 0; i < 2; i++) begin spec_upd_vld = 1'b1; spec_taken = 1'b1; step(); end
    defaults();
    pred_vld = 1'b1; pred_pc_idx = 10'h252; step(); defaults();

    // Retire compaction with same-cycle flush overriding a speculative shift.
    ret_condbr = 3'b101; ret_taken = 3'b001; flush = 1'b1;
    spec_upd_vld = 1'b1; spec_taken = 1'b1; step(); defaults();

    // Collision at entry 0x010, then the follow-up read.
    lookup('h010); train('h010, 1'b1); step(); defaults();
    lookup('h010); step(); defaults();

    // Invalidate during a lookup, with lookups and training during the sweep.
    lookup('h252); inv_req = 1'b1; step(); defaults();
    for (int i = 0; i < DEPTH + 4; i++) begin
      pred_vld = 1'($urandom); pred_pc_idx = IDX_W'($urandom);
      upd_vld = 1'($urandom); upd_idx = IDX_W'($urandom); upd_taken = 1'($urandom);
      inv_req = ($urandom_range(0, 7) == 0) && (i < DEPTH - 2);
      step();
    end
    defaults();
    for (int i = 0; i < DEPTH; i++) begin lookup(i); step(); end
    defaults();

    // Reset 500 cycles into a sweep.
    inv_req = 1'b1; step(); defaults();
    repeat (500) step();
    cpurst = 1'b1; step(); cpurst = 1'b0;
    repeat (DEPTH + 4) step();

    // Random traffic concentrated on a few entries to provoke collisions.
    for (int i = 0; i < 4000; i++) begin
      int ent;
      ent = $urandom_range(0, 7);
      cpurst = ($urandom_range(0, 1499) == 0);
      bht_en = ($urandom_range(0, 9) != 0);
      inv_req = ($urandom_range(0, 499) == 0);
      pred_vld = 1'($urandom);
      pred_pc_idx = IDX_W'(ent ^ int'(m_vghr % DEPTH));
      upd_vld = 1'($urandom);
      upd_idx = ($urandom_range(0, 1) == 0) ? IDX_W'(ent) : IDX_W'($urandom_range(0, 7));
      upd_taken = 1'($urandom);
      spec_upd_vld = 1'($urandom); spec_taken = 1'($urandom);
      ret_condbr = RET_PORTS'($urandom); ret_taken = RET_PORTS'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    defaults();
    step();
    step();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
